mips_fetch_unit: RTL
====================

# mips_fetch_unit

Instruction fetch front end for the MIPS core. It owns the fetch PC, issues word requests to a variable-latency instruction memory and buffers returned instructions with their PCs in a small in-order queue. Decode consumes that queue through a valid/ready handshake. Branch and jump resolution downstream steers fetch with a single-cycle redirect that flushes all younger work, including requests already in flight.

## Interface
Parameters:
- RESET_PC, 32'h00100000, fetch address after reset
- QDEPTH, 4, instruction queue entries (power of two, 2..16)

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word-aligned request address
- imem_resp_valid  in  1  response word valid; cannot be back-pressured
- imem_resp_data  in  32  instruction word
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decode consumes head
- dec_inst  out  32  head instruction
- dec_pc  out  32  PC of head instruction

## Operation
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next non-discarded response.
  - outstanding: accepted requests whose response has not yet returned, 0..QDEPTH.
  - discard: responses still to be dropped, 0..QDEPTH.
  - Queue: QDEPTH entries of {inst, pc}, with read pointer, write pointer and count.
- Credit rule: imem_req_valid = !reset & !redirect_valid & (count + outstanding < QDEPTH).
  - imem_req_valid never depends on imem_req_ready.
  - The credit rule guarantees the queue never overflows.
- imem_req_addr = fetch_pc.
- Request acceptance (valid & ready): fetch_pc += 4, with 32-bit wrap (0xFFFFFFFC -> 0x00000000); outstanding += 1.
- Each imem_resp_valid: outstanding -= 1.
  - If discard > 0: drop the word and decrement discard.
  - Otherwise: push {imem_resp_data, resp_pc} and set resp_pc += 4 (wraps).
- dec_valid = (count != 0). The head is popped on dec_valid & dec_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Redirect (takes priority over everything else in that cycle):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; resp_pc gets the same value.
  - Queue is emptied (count <= 0, pointers reset).
  - discard <= outstanding - imem_resp_valid. No request is issued in the redirect cycle. A response arriving in the redirect cycle is dropped.
  - A simultaneous pop is permitted; the popped entry counts as consumed by decode.
- Back-to-back redirects: the last one wins. discard accumulates correctly because it always reflects outstanding.
- Responses return in request order. A response with outstanding == 0 is a protocol error: it is ignored and does not decrement below 0.

## Timing
- Reset values:
  - fetch_pc = resp_pc = RESET_PC
  - outstanding = discard = count = 0
  - imem_req_valid = 0 and dec_valid = 0 while reset is high
- First cycle after reset deasserts: imem_req_valid = 1, imem_req_addr = RESET_PC.
- Reset asserted mid-operation clears all state at that edge; in-flight responses arriving after reset are not discarded. The memory is reset concurrently.
- Request accepted in cycle N: the response arrives no earlier than N+1. The instruction is pushed at the end of the response cycle R, and dec_valid rises in R+1. There is no response-to-decode bypass.
- Steady state with 1-cycle memory and dec_ready held high: one instruction per cycle after a 2-cycle fill.
- Redirect in cycle N: imem_req_valid = 0 in N; the first request to the new PC is in N+1; dec_valid = 0 in N+1.
- Queue full (count = QDEPTH): imem_req_valid = 0 until a pop occurs. The request may reissue in the cycle after the pop edge.

## Test plan
- **Reset and stream:** release reset with 1-cycle memory returning addr^0xA5A5A5A5 and dec_ready = 1. Required: dec_pc sequence 0x00100000, 0x00100004, 0x00100008 on consecutive cycles from cycle 2, with matching dec_inst.
- **Back-pressure:** hold dec_ready = 0 with QDEPTH = 4. Required: exactly 4 requests accepted, then imem_req_valid = 0. After one pop, exactly one new request is issued. No instruction is lost or duplicated.
- **Redirect with in-flight requests:** use 3-cycle memory latency and redirect to 0x00200002 while 2 requests are outstanding. Required: both stale responses are dropped; the first dec_pc is 0x00200000; no stale PC appears on decode.
- **Redirect coincident with a response and a pop:** required: the coinciding response is dropped, discard = outstanding - 1, and the queue is empty in the next cycle.
- **PC wrap:** redirect to 0xFFFFFFF8. Required: dec_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- **Reset mid-stream:** with 2 requests outstanding, assert reset for 1 cycle. Required: dec_valid = 0, the next request address is 0x00100000, and outstanding and discard are 0.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit
// Instruction fetch front end. Owns the fetch PC, issues word requests to a
// variable-latency instruction memory, and buffers returned words with their
// PCs in an in-order queue that decode drains through a valid/ready handshake.
// A redirect from branch/jump resolution restarts fetch at a new address and
// flushes everything younger, including requests already in flight.
//
// Ports:
//   clk              clock, all state changes on posedge
//   reset            synchronous, active-high
//   redirect_valid   flush and restart fetch at redirect_pc
//   redirect_pc      new fetch address, bits [1:0] ignored
//   imem_req_valid   request to instruction memory (never depends on ready)
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    word-aligned request address (current fetch PC)
//   imem_resp_valid  response word valid, cannot be back-pressured
//   imem_resp_data   instruction word
//   dec_valid        queue head valid
//   dec_ready        decode consumes the head
//   dec_inst         head instruction
//   dec_pc           PC of head instruction
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0010_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc
);

  // Pointer width and counter width (counters must hold the value QDEPTH).
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(QDEPTH);
  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [PW-1:0] PTR_ZERO     = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE      = PW'(1);
  localparam logic [31:0]   PC_STEP      = 32'd4;

  logic [31:0]   fetch_pc_r;
  logic [31:0]   resp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] discard_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [31:0]   inst_mem_r [QDEPTH];
  logic [31:0]   pc_mem_r   [QDEPTH];

  logic [CW:0]   credit_sum_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          resp_live_s;
  logic          drop_s;
  logic          push_s;
  logic          dec_valid_s;
  logic          pop_s;
  logic [31:0]   redirect_addr_s;
  logic [CW-1:0] outstanding_next_s;
  logic [CW-1:0] count_next_s;

  // Queued entries plus in-flight requests bound the queue occupancy, so a
  // request is only issued while that sum leaves room for its response.
  assign credit_sum_s    = {1'b0, count_r} + {1'b0, outstanding_r};
  assign req_valid_s     = !reset && !redirect_valid && (credit_sum_s < CREDIT_LIMIT);
  assign req_fire_s      = req_valid_s && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_live_s     = imem_resp_valid && (outstanding_r != CNT_ZERO);
  assign drop_s          = resp_live_s && (discard_r != CNT_ZERO);
  assign push_s          = resp_live_s && (discard_r == CNT_ZERO) && !redirect_valid;

  assign dec_valid_s     = !reset && (count_r != CNT_ZERO);
  assign pop_s           = dec_valid_s && dec_ready;
  assign redirect_addr_s = {redirect_pc[31:2], 2'b00};

  assign imem_req_valid  = req_valid_s;
  assign imem_req_addr   = fetch_pc_r;
  assign dec_valid       = dec_valid_s;
  assign dec_inst        = inst_mem_r[rd_ptr_r];
  assign dec_pc          = pc_mem_r[rd_ptr_r];

  // Next in-flight request count from this cycle's issue and return.
  always_comb begin
    outstanding_next_s = outstanding_r;
    case ({req_fire_s, resp_live_s})
      2'b10:   outstanding_next_s = outstanding_r + CNT_ONE;
      2'b01:   outstanding_next_s = outstanding_r - CNT_ONE;
      default: outstanding_next_s = outstanding_r;
    endcase
  end

  // Next queue occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Fetch/response PCs, credit counters and queue pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      discard_r     <= CNT_ZERO;
      count_r       <= CNT_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
    end else if (redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old
      // path, so the drop budget is simply the remaining outstanding count.
      // No request fires here, so outstanding_next_s already excludes a
      // response returning in this same cycle.
      fetch_pc_r    <= redirect_addr_s;
      resp_pc_r     <= redirect_addr_s;
      outstanding_r <= outstanding_next_s;
      discard_r     <= outstanding_next_s;
      count_r       <= CNT_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
    end else begin
      outstanding_r <= outstanding_next_s;
      count_r       <= count_next_s;
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      if (drop_s) begin
        discard_r <= discard_r - CNT_ONE;
      end
      if (push_s) begin
        resp_pc_r <= resp_pc_r + PC_STEP;
        wr_ptr_r  <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Queue storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      inst_mem_r[wr_ptr_r] <= imem_resp_data;
      pc_mem_r[wr_ptr_r]   <= resp_pc_r;
    end
  end

endmodule
